// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, data word and the registered ALU response.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // One response slot: ALU result plus its flags.
    typedef struct packed {
        word_t result;
        logic  neg;
        logic  zero;
        logic  ovf;
    } alu_rsp_t;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between an ALU user (master) and the combinational alu.
interface alu_if;

    cpu_types_pkg::aluop_t op;
    cpu_types_pkg::word_t  port_a;
    cpu_types_pkg::word_t  port_b;
    cpu_types_pkg::word_t  result;
    logic                  neg;
    logic                  zero;
    logic                  ovf;

    modport master (output op, port_a, port_b, input result, neg, zero, ovf);
    modport slave  (input op, port_a, port_b, output result, neg, zero, ovf);

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU. Shifts move port_b by port_a[4:0]; SUB is a - b;
// overflow is only meaningful for ADD/SUB and is zero for all other ops.
module alu
    import cpu_types_pkg::*;
(
    alu_if.slave bus
);

    word_t      w_result;
    logic       w_ovf;
    logic [4:0] w_shamt;

    assign w_shamt = bus.port_a[4:0];

    // Operation decode and signed-overflow detection.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        w_result = '0;
        w_ovf    = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                w_result = bus.port_a + bus.port_b;
                w_ovf    = (bus.port_a[WORD_W-1] == bus.port_b[WORD_W-1]) &&
                           (w_result[WORD_W-1] != bus.port_a[WORD_W-1]);
            end
            ALU_SUB: begin
                w_result = bus.port_a - bus.port_b;
                w_ovf    = (bus.port_a[WORD_W-1] != bus.port_b[WORD_W-1]) &&
                           (w_result[WORD_W-1] != bus.port_a[WORD_W-1]);
            end
            ALU_AND:  w_result = bus.port_a & bus.port_b;
            ALU_OR:   w_result = bus.port_a | bus.port_b;
            ALU_XOR:  w_result = bus.port_a ^ bus.port_b;
            ALU_SLL:  w_result = bus.port_b << w_shamt;
            ALU_SRL:  w_result = bus.port_b >> w_shamt;
            ALU_SRA:  w_result = word_t'($signed(bus.port_b) >>> w_shamt);
            ALU_SLT:  w_result = {{(WORD_W-1){1'b0}}, ($signed(bus.port_a) < $signed(bus.port_b))};
            ALU_SLTU: w_result = {{(WORD_W-1){1'b0}}, (bus.port_a < bus.port_b)};
            default:  w_result = '0;
        endcase
    end

    assign bus.result = w_result;
    assign bus.neg    = w_result[WORD_W-1];
    assign bus.zero   = (w_result == '0);
    assign bus.ovf    = w_ovf;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one combinational alu.
// Each cycle at most one operation is granted; its result and flags are
// registered into that requester's response slot (valid/ready handshake).
// Optional build macro ALU_ARB_LOCK_EN adds req_lock: while the last-granted
// requester holds its lock high it stays favoured for back-to-back sequences.
// Only NREQ = 2 is supported.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NREQ-1:0]               req_valid,
    input  aluop_t [NREQ-1:0]             req_op,
    input  logic [NREQ-1:0][WORD_W-1:0]   req_a,
    input  logic [NREQ-1:0][WORD_W-1:0]   req_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]               req_lock,
`endif
    output logic [NREQ-1:0]               req_ready,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [NREQ-1:0][WORD_W-1:0]   rsp_result,
    output logic [NREQ-1:0]               rsp_neg,
    output logic [NREQ-1:0]               rsp_zero,
    output logic [NREQ-1:0]               rsp_ovf,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic                          busy
);

    logic                      r_prio;       // favoured requester
    logic [NREQ-1:0]           r_rsp_valid;
    alu_rsp_t [NREQ-1:0]       r_rsp;

    logic [NREQ-1:0]           w_elig;
    logic [NREQ-1:0]           w_grant;
    logic                      w_fav;
    logic                      w_any;
    logic                      w_gidx;
    alu_rsp_t                  w_alu_rsp;

    alu_if u_alu_bus ();

    alu u_alu (
        .bus (u_alu_bus)
    );

    // A requester may issue when its slot is empty or is being drained now.
    assign w_elig = req_valid & (~r_rsp_valid | rsp_ready);

`ifdef ALU_ARB_LOCK_EN
    logic r_has_last;
    logic w_last;

    // After any grant r_prio points at the other requester, so the last
    // granted one is always ~r_prio; a held lock keeps it favoured.
    assign w_last = ~r_prio;
    assign w_fav  = (r_has_last && req_lock[w_last]) ? w_last : r_prio;

    // Remember whether anything has been granted since reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_has_last <= 1'b0;
        end else if (w_any) begin
            r_has_last <= 1'b1;
        end
    end
`else
    assign w_fav = r_prio;
`endif

    // Grant: favoured requester on contention, otherwise the sole eligible one.
    always_comb begin
        w_grant = '0;
        if (!RST) begin
            if (&w_elig) begin
                w_grant[w_fav] = 1'b1;
            end else begin
                w_grant = w_elig;
            end
        end
    end

    assign w_any     = |w_grant;
    assign w_gidx    = w_grant[1];
    assign req_ready = w_grant;

    // Drive the shared ALU from the granted requester, or a benign ADD 0,0.
    always_comb begin
        u_alu_bus.op     = ALU_ADD;
        u_alu_bus.port_a = '0;
        u_alu_bus.port_b = '0;
        if (w_any) begin
            u_alu_bus.op     = req_op[w_gidx];
            u_alu_bus.port_a = req_a[w_gidx];
            u_alu_bus.port_b = req_b[w_gidx];
        end
    end

    assign w_alu_rsp = '{result: u_alu_bus.result,
                         neg:    u_alu_bus.neg,
                         zero:   u_alu_bus.zero,
                         ovf:    u_alu_bus.ovf};

    // Rotate priority to the non-granted requester after every grant.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments for all clocked state avoid update-order races.
        if (RST) begin
            r_prio <= 1'b0;
        end else if (w_any) begin
            r_prio <= ~w_gidx;
        end
    end

    // Response slots: a new grant loads the slot; otherwise a pop clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the slot payload is reset too, so outputs read zero after reset.
            r_rsp_valid <= '0;
            r_rsp       <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp[i]       <= w_alu_rsp;
                end else if (r_rsp_valid[i] && rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Unpack the slot structs onto the response ports.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_result[i] = r_rsp[i].result;
            rsp_neg[i]    = r_rsp[i].neg;
            rsp_zero[i]   = r_rsp[i].zero;
            rsp_ovf[i]    = r_rsp[i].ovf;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign busy      = |r_rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run checked against a behavioural model of the arbiter and ALU.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic               CLK = 1'b0;
    logic               RST;
    logic [1:0]         req_valid;
    aluop_t [1:0]       req_op;
    logic [1:0][31:0]   req_a;
    logic [1:0][31:0]   req_b;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [1:0][31:0]   rsp_result;
    logic [1:0]         rsp_neg;
    logic [1:0]         rsp_zero;
    logic [1:0]         rsp_ovf;
    logic [1:0]         rsp_ready;
    logic               busy;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0]         req_lock;
`endif

    int n_cmp;
    int n_bad;

    // Behavioural model state
    bit          m_valid [2];
    logic [31:0] m_res   [2];
    bit          m_neg   [2];
    bit          m_zero  [2];
    bit          m_ovf   [2];
    int          m_prio;
    int          m_last;

    alu_arbiter #(.NREQ(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_neg    (rsp_neg),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // ALU reference using wide signed arithmetic.
    function automatic void alu_model(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output bit n, output bit z, output bit o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic [4:0] sh = a[4:0];
        o = 1'b0;
        case (op)
            ALU_ADD:  begin s = sa + sb; r = 32'(s); o = (s > MAX_S) || (s < MIN_S); end
            ALU_SUB:  begin s = sa - sb; r = 32'(s); o = (s > MAX_S) || (s < MIN_S); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = b << sh;
            ALU_SRL:  r = b >> sh;
            ALU_SRA:  r = 32'($signed(b) >>> sh);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default:  r = 32'd0;
        endcase
        n = r[31];
        z = (r == 32'd0);
    endfunction

    function automatic int model_grant();
        bit e0, e1;
        int fav;
        if (RST) return -1;
        e0  = req_valid[0] && (!m_valid[0] || rsp_ready[0]);
        e1  = req_valid[1] && (!m_valid[1] || rsp_ready[1]);
        fav = m_prio;
`ifdef ALU_ARB_LOCK_EN
        if (m_last >= 0 && req_lock[m_last]) fav = m_last;
`endif
        if (e0 && e1) return fav;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_res[i] = '0; m_neg[i] = 0; m_zero[i] = 0; m_ovf[i] = 0;
        end
        m_prio = 0;
        m_last = -1;
    endtask

    // Advance the model across one rising edge, given this cycle's grant.
    task automatic clock_model(input int g);
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (g == i) begin
                alu_model(req_op[i], req_a[i], req_b[i], m_res[i], m_neg[i], m_zero[i], m_ovf[i]);
                m_valid[i] = 1;
            end else if (m_valid[i] && rsp_ready[i]) begin
                m_valid[i] = 0;
            end
        end
        if (g >= 0) begin
            m_prio = 1 - g;
            m_last = g;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
`ifdef ALU_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = ALU_ADD; req_a[1] = 32'd2; req_b[1] = 32'd2;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_cmp++;
        if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (rsp_result !== 64'd0) begin n_bad++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        n_cmp++;
        if ({rsp_neg, rsp_zero, rsp_ovf} !== 6'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {rsp_neg, rsp_zero, rsp_ovf});
        end
        req_valid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single();
        int g;
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'h7FFF_FFFF; req_b[0] = 32'd1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++;
        if (rsp_result[0] !== 32'h8000_0000) begin
            n_bad++; $display("FAIL single_result: got %h want 80000000", rsp_result[0]);
        end
        n_cmp++;
        if ({rsp_ovf[0], rsp_neg[0], rsp_zero[0]} !== 3'b110) begin
            n_bad++; $display("FAIL single_flags(ovf,neg,zero): got %b want 110", {rsp_ovf[0], rsp_neg[0], rsp_zero[0]});
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL single_pop: got %b want 00", rsp_valid); end
    endtask

    task automatic test_contention();
        int g;
        logic [1:0] exp;
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_op[0] = ALU_SUB; req_a[0] = 32'd5;         req_b[0] = 32'd5;
        req_op[1] = ALU_SLT; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (req_ready !== exp) begin n_bad++; $display("FAIL contention_grant[%0d]: got %b want %b", k, req_ready, exp); end
            if (k == 1) begin
                n_cmp++;
                if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd0 || rsp_zero[0] !== 1'b1) begin
                    n_bad++; $display("FAIL contention_rsp0: got v=%b r=%h z=%b want v=1 r=0 z=1", rsp_valid[0], rsp_result[0], rsp_zero[0]);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== 32'd1) begin
                    n_bad++; $display("FAIL contention_rsp1: got v=%b r=%h want v=1 r=1", rsp_valid[1], rsp_result[1]);
                end
            end
            g = model_grant();
            clock_model(g);
        end
    endtask

    task automatic test_backpressure();
        int g;
        logic [31:0] hold, prev;
        do_reset();
        req_valid = 2'b10;
        req_op[1] = ALU_XOR; req_a[1] = $urandom; req_b[1] = $urandom;
        hold = req_a[1] ^ req_b[1];
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_fill_grant: got %b want 10", req_ready); end
        g = model_grant();
        clock_model(g);
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            req_valid = 2'b11;
            rsp_ready = 2'b01;
            req_op[0] = ALU_ADD; req_a[0] = $urandom; req_b[0] = $urandom;
            #1;
            n_cmp++;
            if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_grant[%0d]: got %b want 01", k, req_ready); end
            n_cmp++;
            if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== hold) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%h want v=1 r=%h", k, rsp_valid[1], rsp_result[1], hold);
            end
            if (k > 0) begin
                n_cmp++;
                if (rsp_result[0] !== prev) begin n_bad++; $display("FAIL bp_rsp0[%0d]: got %h want %h", k, rsp_result[0], prev); end
            end
            prev = req_a[0] + req_b[0];
            g = model_grant();
            clock_model(g);
        end
    endtask

    task automatic test_pop_push();
        int g;
        do_reset();
        req_valid = 2'b01;
        req_op[0] = ALU_ADD; req_a[0] = 32'd3; req_b[0] = 32'd4;
        #1;
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        rsp_ready = 2'b01;
        req_op[0] = ALU_SLL; req_a[0] = 32'd4; req_b[0] = 32'd1;
        #1;
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd7) begin
            n_bad++; $display("FAIL pp_pre: got v=%b r=%h want v=1 r=7", rsp_valid[0], rsp_result[0]);
        end
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL pp_grant: got %b want 01", req_ready); end
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'h10) begin
            n_bad++; $display("FAIL pp_result: got v=%b r=%h want v=1 r=10", rsp_valid[0], rsp_result[0]);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        do_reset();
        req_valid = 2'b10;
        req_op[1] = ALU_OR; req_a[1] = 32'h1234_0000; req_b[1] = 32'h0000_5678;
        #1;
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL rmid_pre: got %b want 10", rsp_valid); end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_async_clear: got v=%b busy=%b want v=00 busy=0", rsp_valid, busy);
        end
        n_cmp++;
        if (rsp_result !== 64'd0) begin n_bad++; $display("FAIL rmid_result: got %h want 0", rsp_result); end
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_op[0] = ALU_AND; req_a[0] = $urandom; req_b[0] = $urandom;
        req_op[1] = ALU_AND; req_a[1] = $urandom; req_b[1] = $urandom;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rmid_prio: got %b want 01", req_ready); end
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        req_valid = 2'b00;
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        int g;
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b10;
        req_lock  = 2'b10;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        req_op[1] = ALU_ADD; req_a[1] = 32'd2; req_b[1] = 32'd2;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin n_bad++; $display("FAIL lock_first: got %b want 10", req_ready); end
        g = model_grant();
        clock_model(g);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            req_valid = 2'b11;
            #1;
            n_cmp++;
            if (req_ready !== 2'b10) begin n_bad++; $display("FAIL lock_hold[%0d]: got %b want 10", k, req_ready); end
            g = model_grant();
            clock_model(g);
        end
        @(negedge CLK);
        req_lock = 2'b00;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin n_bad++; $display("FAIL lock_release: got %b want 01", req_ready); end
        g = model_grant();
        clock_model(g);
        @(negedge CLK);
        req_valid = 2'b00;
    endtask
`endif

    task automatic test_random();
        int g;
        int last_g;
        logic [1:0] exp_ready;
        do_reset();
        last_g = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                // Operands must stay put while a request waits for a grant.
                if (!(req_valid[i] && last_g != i)) begin
                    req_valid[i] = ($urandom_range(0, 9) < 7);
                    req_op[i]    = aluop_t'($urandom_range(0, 9));
                    req_a[i]     = pick_word();
                    req_b[i]     = pick_word();
                end
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
`ifdef ALU_ARB_LOCK_EN
            req_lock = 2'($urandom_range(0, 3));
`endif
            #1;
            g = model_grant();
            exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", k, req_ready, exp_ready);
            end
            n_cmp++;
            if (rsp_valid !== {m_valid[1], m_valid[0]} || busy !== (m_valid[0] | m_valid[1])) begin
                n_bad++; $display("FAIL rnd_valid[%0d]: got v=%b busy=%b want v=%b%b", k, rsp_valid, busy, m_valid[1], m_valid[0]);
            end
            for (int i = 0; i < 2; i++) begin
                if (m_valid[i]) begin
                    n_cmp++;
                    if (rsp_result[i] !== m_res[i] || rsp_neg[i] !== m_neg[i] ||
                        rsp_zero[i] !== m_zero[i] || rsp_ovf[i] !== m_ovf[i]) begin
                        n_bad++;
                        $display("FAIL rnd_rsp%0d[%0d]: got r=%h n=%b z=%b o=%b want r=%h n=%b z=%b o=%b",
                                 i, k, rsp_result[i], rsp_neg[i], rsp_zero[i], rsp_ovf[i],
                                 m_res[i], m_neg[i], m_zero[i], m_ovf[i]);
                    end
                end
            end
            clock_model(g);
            last_g = g;
        end
        @(negedge CLK);
        req_valid = 2'b00;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op = '0;
        req_a = '0;
        req_b = '0;
`ifdef ALU_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_pop_push();
        test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
